timer_ctrl: RTL and testbench
=============================

// Module: timer_ctrl
// PURPOSE
//  Controller for the core's constant-countdown timer: owns the TCFG config register and the TVAL countdown register.
//  Sequences the countdown through a tick prescaler and detects expiry.
//  Runs one-shot or periodic reload, and raises/clears the timer interrupt line (ESTAT.IS[11]).
//  Sits beside the CSR file; CSR writes to TCFG/TICLR arrive on dedicated strobes, CSR reads take tcfg/tval directly.
// PARAMETERS
//  TIMER_W   32  counter width (8..32); TCFG/TVAL implemented bits, upper bits read 0
//  PRESCALE  1   clk cycles per countdown tick (>=1); 1 = tick every cycle
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   asynchronous, active-low reset
//  tcfg_we       in   1   CSR write strobe to TCFG
//  tcfg_wdata    in   32  TCFG write data: [0]=En, [1]=Periodic, [TIMER_W-1:2]=InitVal
//  ticlr_we      in   1   CSR write strobe to TICLR
//  ticlr_wdata   in   32  TICLR write data; [0]=1 clears interrupt
//  freeze        in   1   debug halt: prescaler and countdown hold while 1
//  tcfg          out  32  TCFG readback, zero-extended above TIMER_W
//  tval          out  32  TVAL readback, zero-extended above TIMER_W
//  timer_int     out  1   level interrupt (TI), sticky until cleared
//  expire_p      out  1   one-cycle pulse on each expiry
//  state         out  2   00 IDLE, 01 RUN, 10 DONE
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE, prescaler 0.
//  reload = {tcfg[TIMER_W-1:2],2'b00}.
//  TCFG write (takes effect next edge):
//    tcfg <= tcfg_wdata[TIMER_W-1:0]; prescaler <= 0.
//    En=1: tval <= {tcfg_wdata[TIMER_W-1:2],2'b00}; state <= RUN.
//    En=0: tval holds; state <= IDLE.
//    A write overrides any tick in that cycle; timer_int unaffected.
//  Prescaler (RUN && !freeze only):
//    counts 0..PRESCALE-1 and wraps.
//    tick = (prescaler==PRESCALE-1) && RUN && !freeze && !tcfg_we.
//    Holds its value in IDLE/DONE/freeze.
//  Tick, tval!=0: tval <= tval-1.
//  Tick, tval==0 (expiry): expire_p=1 next cycle; timer_int <= 1.
//    Periodic=1: tval <= reload, stay RUN.
//    Periodic=0: tval stays 0, state <= DONE.
//  Period = (reload+1) ticks.
//  InitVal=0 periodic expires every tick.
//  States: IDLE-(TCFG En=1)->RUN; RUN-(one-shot expiry)->DONE; RUN/DONE-(TCFG En=0)->IDLE;
//    DONE-(TCFG En=1)->RUN. DONE ignores ticks.
//  TICLR write with [0]=1 clears timer_int.
//    [0]=0 is a no-op; TICLR never alters tval/state.
//  Simultaneous expiry and TICLR clear: set wins, timer_int=1.
//  freeze deasserted: resume with the prescaler phase preserved.
//  Reset mid-count: returns to the reset state immediately; no expire_p.
// TESTING
//  - Reset, then TCFG=0x0000_0009 (InitVal=2, En, one-shot), PRESCALE=1:
//    tval 8,7..0; at tval=0 the next tick gives timer_int=1, expire_p 1 cycle, state DONE, tval held 0.
//  - TCFG=0x0000_0007 periodic (reload 4):
//    expire_p every 5 cycles, tval 4..0,4..; TICLR=1 clears timer_int.
//  - TICLR write in the same cycle as an expiry -> timer_int stays 1.
//  - PRESCALE=4, TCFG=0x5 (reload 4):
//    tval decrements every 4 clks; freeze 3 clks mid-count adds exactly 3 clks of delay.
//  - TCFG write En=0 while RUN with tval=3:
//    state IDLE, tval frozen at 3; rewrite En=1 reloads.
//  - rst_n low mid-count with timer_int=1:
//    all outputs 0 asynchronously; TCFG write to DONE-state timer restarts RUN.

Source files
------------

// File: rtl/timer_ctrl.sv
// Constant-countdown timer controller: TCFG/TVAL registers, tick prescaler, expiry
// detection, one-shot/periodic reload and sticky timer interrupt.
module timer_ctrl #(
  parameter int TIMER_W  = 32,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wdata,
  input  logic        ticlr_we,
  input  logic [31:0] ticlr_wdata,
  input  logic        freeze,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        timer_int,
  output logic        expire_p,
  output logic [1:0]  state
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t             st_q;
  state_t             st_d;
  logic [TIMER_W-1:0] tcfg_q;
  logic [TIMER_W-1:0] tval_q;
  logic [PS_W-1:0]    presc_q;
  logic               int_q;
  logic               exp_q;

  logic               wr_en;
  logic               advance;
  logic               tick;
  logic               expiry;
  logic               int_clr;
  logic [TIMER_W-1:0] wr_reload;
  logic [TIMER_W-1:0] reload;

  assign wr_en     = tcfg_wdata[0];
  assign wr_reload = {tcfg_wdata[TIMER_W-1:2], 2'b00};
  assign reload    = {tcfg_q[TIMER_W-1:2], 2'b00};
  assign int_clr   = ticlr_we && ticlr_wdata[0];

  // A TCFG write in the same cycle suppresses both prescaler advance and tick.
  assign advance = (st_q == S_RUN) && !freeze && !tcfg_we;
  assign tick    = advance && (presc_q == PS_MAX);
  assign expiry  = tick && (tval_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= S_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    if (tcfg_we) begin
      st_d = wr_en ? S_RUN : S_IDLE;
    end else if (expiry && !tcfg_q[1]) begin
      st_d = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcfg_q  <= '0;
      tval_q  <= '0;
      presc_q <= '0;
    end else if (tcfg_we) begin
      tcfg_q  <= tcfg_wdata[TIMER_W-1:0];
      presc_q <= '0;
      if (wr_en) begin
        tval_q <= wr_reload;
      end
    end else begin
      if (advance) begin
        presc_q <= (presc_q == PS_MAX) ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
        if (tval_q != '0) begin
          tval_q <= tval_q - 1'b1;
        end else if (tcfg_q[1]) begin
          tval_q <= reload;
        end
      end
    end
  end

  // Setting on expiry takes priority over a simultaneous TICLR clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_q <= 1'b0;
      exp_q <= 1'b0;
    end else begin
      exp_q <= expiry;
      if (expiry) begin
        int_q <= 1'b1;
      end else if (int_clr) begin
        int_q <= 1'b0;
      end
    end
  end

  assign tcfg      = 32'(tcfg_q);
  assign tval      = 32'(tval_q);
  assign timer_int = int_q;
  assign expire_p  = exp_q;
  assign state     = st_q;

  logic unused_wdata;
  assign unused_wdata = ^{ticlr_wdata[31:1], tcfg_wdata};

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: a 16-bit PRESCALE=1 instance and a 32-bit PRESCALE=4 instance on shared stimulus.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tcfg_we = 1'b0;
  logic [31:0] tcfg_wdata = '0;
  logic        ticlr_we = 1'b0;
  logic [31:0] ticlr_wdata = '0;
  logic        freeze = 1'b0;

  logic [31:0] d1_tcfg, d1_tval, d4_tcfg, d4_tval;
  logic        d1_int, d1_exp, d4_int, d4_exp;
  logic [1:0]  d1_state, d4_state;

  always #5 clk = ~clk;

  timer_ctrl #(.TIMER_W(16), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
    .ticlr_we(ticlr_we), .ticlr_wdata(ticlr_wdata), .freeze(freeze),
    .tcfg(d1_tcfg), .tval(d1_tval), .timer_int(d1_int), .expire_p(d1_exp), .state(d1_state)
  );

  timer_ctrl #(.TIMER_W(32), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
    .ticlr_we(ticlr_we), .ticlr_wdata(ticlr_wdata), .freeze(freeze),
    .tcfg(d4_tcfg), .tval(d4_tval), .timer_int(d4_int), .expire_p(d4_exp), .state(d4_state)
  );

  typedef struct {
    bit          sel;      // 0 = dut1, 1 = dut4
    bit          twe;
    logic [31:0] twd;
    bit          cwe;
    logic [31:0] cwd;
    bit          frz;
    logic [31:0] e_tcfg;
    logic [31:0] e_tval;
    logic        e_int;
    logic        e_exp;
    logic [1:0]  e_state;
  } vec_t;

  vec_t tbl [14];
  vec_t sb_q [$];
  int   total = 0;
  int   passed = 0;
  int   stepn = 0;

  function automatic vec_t mk(bit sel, bit twe, logic [31:0] twd, bit cwe, logic [31:0] cwd, bit frz,
                              logic [31:0] etcfg, logic [31:0] etval, logic eint, logic eexp,
                              logic [1:0] est);
    vec_t v;
    v.sel = sel; v.twe = twe; v.twd = twd; v.cwe = cwe; v.cwd = cwd; v.frz = frz;
    v.e_tcfg = etcfg; v.e_tval = etval; v.e_int = eint; v.e_exp = eexp; v.e_state = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got 0x%08h want 0x%08h", name, stepn, act, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tcfg1"}, d1_tcfg, 0);
    chk({tag, "_tval1"}, d1_tval, 0);
    chk({tag, "_int1"}, 32'(d1_int), 0);
    chk({tag, "_exp1"}, 32'(d1_exp), 0);
    chk({tag, "_state1"}, 32'(d1_state), 0);
    chk({tag, "_tval4"}, d4_tval, 0);
    chk({tag, "_int4"}, 32'(d4_int), 0);
    chk({tag, "_state4"}, 32'(d4_state), 0);
  endtask

  // Called at a negedge: drive, push expectation, sample 1ns after the posedge, return at next negedge.
  task automatic step(input vec_t v);
    vec_t e;
    tcfg_we = v.twe; tcfg_wdata = v.twd;
    ticlr_we = v.cwe; ticlr_wdata = v.cwd;
    freeze = v.frz;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    stepn++;
    if (e.sel) begin
      chk("tcfg", d4_tcfg, e.e_tcfg);
      chk("tval", d4_tval, e.e_tval);
      chk("timer_int", 32'(d4_int), 32'(e.e_int));
      chk("expire_p", 32'(d4_exp), 32'(e.e_exp));
      chk("state", 32'(d4_state), 32'(e.e_state));
    end else begin
      chk("tcfg", d1_tcfg, e.e_tcfg);
      chk("tval", d1_tval, e.e_tval);
      chk("timer_int", 32'(d1_int), 32'(e.e_int));
      chk("expire_p", 32'(d1_exp), 32'(e.e_exp));
      chk("state", 32'(d1_state), 32'(e.e_state));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    tcfg_we = 0; tcfg_wdata = '0; ticlr_we = 0; ticlr_wdata = '0; freeze = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    bit frz;
    logic        ei;
    logic [31:0] et;

    // one-shot, reload 8, 16-bit instance; upper write bits must read back 0
    tbl[0]  = mk(0, 1, 32'hABCD_0009, 0, 0, 0, 32'h9, 8, 0, 0, 2'b01);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 32'h9, 7, 0, 0, 2'b01);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 32'h9, 6, 0, 0, 2'b01);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 32'h9, 5, 0, 0, 2'b01);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 32'h9, 4, 0, 0, 2'b01);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 32'h9, 3, 0, 0, 2'b01);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 32'h9, 2, 0, 0, 2'b01);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 32'h9, 1, 0, 0, 2'b01);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 32'h9, 0, 0, 0, 2'b01);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 32'h9, 0, 1, 1, 2'b10);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 32'h9, 0, 1, 0, 2'b10);
    tbl[11] = mk(0, 0, 0, 1, 32'h0, 0, 32'h9, 0, 1, 0, 2'b10);
    tbl[12] = mk(0, 0, 0, 1, 32'hFFFF_FFFE, 0, 32'h9, 0, 1, 0, 2'b10);
    tbl[13] = mk(0, 0, 0, 1, 32'h1, 0, 32'h9, 0, 0, 0, 2'b10);

    rst_n = 0;
    #1;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) step(tbl[i]);

    // periodic reload 4: period 5, TICLR clear, then clear coinciding with expiry
    do_reset();
    step(mk(0, 1, 32'h7, 0, 0, 0, 32'h7, 4, 0, 0, 2'b01));
    for (int k = 1; k <= 17; k++) begin
      bit c;
      c  = (k == 13) || (k == 15);
      et = (k % 5 == 0) ? 32'd4 : 32'(4 - (k % 5));
      ei = (k >= 5) && !(k == 13 || k == 14);
      step(mk(0, 0, 0, c, c ? 32'h1 : 32'h0, 0, 32'h7, et, ei, (k % 5 == 0), 2'b01));
    end

    // PRESCALE=4, one-shot reload 4, freeze for 3 clocks mid-count
    do_reset();
    step(mk(1, 1, 32'h5, 0, 0, 0, 32'h5, 4, 0, 0, 2'b01));
    e = 0;
    for (int k = 1; k <= 26; k++) begin
      frz = (k >= 6) && (k <= 8);
      if (!frz) e++;
      et = (e >= 20) ? 32'd0 : 32'(4 - e / 4);
      step(mk(1, 0, 0, 0, 0, frz, 32'h5, et, (e >= 20), (e == 20), (e >= 20) ? 2'b10 : 2'b01));
    end

    // En=0 write while running with tval=3 holds tval; En=1 rewrite reloads
    do_reset();
    step(mk(0, 1, 32'h5, 0, 0, 0, 32'h5, 4, 0, 0, 2'b01));
    step(mk(0, 0, 0, 0, 0, 0, 32'h5, 3, 0, 0, 2'b01));
    step(mk(0, 1, 32'h4, 0, 0, 0, 32'h4, 3, 0, 0, 2'b00));
    step(mk(0, 0, 0, 0, 0, 0, 32'h4, 3, 0, 0, 2'b00));
    step(mk(0, 0, 0, 0, 0, 1, 32'h4, 3, 0, 0, 2'b00));
    step(mk(0, 1, 32'h5, 0, 0, 0, 32'h5, 4, 0, 0, 2'b01));
    step(mk(0, 0, 0, 0, 0, 0, 32'h5, 3, 0, 0, 2'b01));

    // async reset mid-count with timer_int set
    do_reset();
    step(mk(0, 1, 32'h7, 0, 0, 0, 32'h7, 4, 0, 0, 2'b01));
    for (int k = 1; k <= 5; k++)
      step(mk(0, 0, 0, 0, 0, 0, 32'h7, (k == 5) ? 32'd4 : 32'(4 - k), (k == 5), (k == 5), 2'b01));
    #2;
    rst_n = 0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("held_rst");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // InitVal 0 one-shot expires on the first tick; DONE restarts on a new write
    step(mk(0, 1, 32'h1, 0, 0, 0, 32'h1, 0, 0, 0, 2'b01));
    step(mk(0, 0, 0, 0, 0, 0, 32'h1, 0, 1, 1, 2'b10));
    step(mk(0, 0, 0, 0, 0, 0, 32'h1, 0, 1, 0, 2'b10));
    step(mk(0, 1, 32'h9, 0, 0, 0, 32'h9, 8, 1, 0, 2'b01));
    step(mk(0, 0, 0, 0, 0, 0, 32'h9, 7, 1, 0, 2'b01));

    // InitVal 0 periodic expires every tick
    step(mk(0, 1, 32'h3, 0, 0, 0, 32'h3, 0, 1, 0, 2'b01));
    for (int k = 0; k < 3; k++)
      step(mk(0, 0, 0, 0, 0, 0, 32'h3, 0, 1, 1, 2'b01));
    step(mk(0, 0, 0, 1, 32'h1, 1, 32'h3, 0, 0, 0, 2'b01));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
